// File: rtl/mips_defines.sv
// Shared definitions for the MIPS core: datapath widths, ALU operation class
// and opcode encodings, and the divider state encoding.
package mips_defines;

  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned RegDataWidth = 32;
  localparam int unsigned AluselWidth  = 3;
  localparam int unsigned AluopWidth   = 8;

  typedef enum logic [AluselWidth-1:0] {
    AluselNop   = 3'd0,
    AluselLogic = 3'd1,
    AluselShift = 3'd2,
    AluselArith = 3'd3,
    AluselDiv   = 3'd4
  } alusel_e;

  // Opcodes follow the MIPS R-type funct field values.
  typedef enum logic [AluopWidth-1:0] {
    AluopSll  = 8'h00,
    AluopSrl  = 8'h02,
    AluopSra  = 8'h03,
    AluopDiv  = 8'h1a,
    AluopDivu = 8'h1b,
    AluopAdd  = 8'h20,
    AluopAddu = 8'h21,
    AluopSub  = 8'h22,
    AluopSubu = 8'h23,
    AluopAnd  = 8'h24,
    AluopOr   = 8'h25,
    AluopXor  = 8'h26,
    AluopNor  = 8'h27,
    AluopSlt  = 8'h2a,
    AluopSltu = 8'h2b
  } aluop_e;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider for the execute stage.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           a division is presented this cycle
//   signed_i          treat operands as two's complement
//   flush_i           abort any division and return to idle
//   a_i, b_i          dividend, divisor
//   stall_o           division accepted or in flight (combinational)
//   done_o            result valid this cycle (DONE state)
//   quot_o, rem_o     sign-corrected quotient / remainder
module ex_div
  import mips_defines::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             flush_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [Width-1:0] quot_o,
  output logic [Width-1:0] rem_o
);

  localparam int unsigned CntW = $clog2(Width);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [Width-1:0] divisor_q, divisor_d, dividend_q, dividend_d;
  logic             neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d, div0_q, div0_d;

  logic             accept, a_neg, b_neg;
  logic [Width-1:0] a_mag, b_mag;
  logic [Width:0]   rem_shift, trial;

  assign accept    = (state_q == DivIdle) && start_i && !flush_i;
  assign a_neg     = signed_i & a_i[Width-1];
  assign b_neg     = signed_i & b_i[Width-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;
  // The dividend shifts out of quot_q MSB-first while quotient bits shift in.
  assign rem_shift = {rem_q, quot_q[Width-1]};
  assign trial     = rem_shift - {1'b0, divisor_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DivIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = DivIdle;
    end else begin
      case (state_q)
        DivIdle: if (start_i) state_d = (b_i == '0) ? DivDone : DivBusy;
        DivBusy: if (cnt_q == CntW'(Width - 1)) state_d = DivDone;
        DivDone: state_d = DivIdle;
        default: state_d = DivIdle;
      endcase
    end
  end

  always_comb begin
    stall_o = ((state_q == DivIdle) && start_i && !flush_i) ||
              ((state_q == DivBusy) && !flush_i);
    done_o  = (state_q == DivDone);
    quot_o  = div0_q ? '1 : (neg_quot_q ? -quot_q : quot_q);
    rem_o   = div0_q ? dividend_q : (neg_rem_q ? -rem_q : rem_q);
  end

  always_comb begin
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div0_d     = div0_q;
    if (accept) begin
      cnt_d      = '0;
      quot_d     = a_mag;
      rem_d      = '0;
      divisor_d  = b_mag;
      dividend_d = a_i;
      neg_quot_d = a_neg ^ b_neg;
      neg_rem_d  = a_neg;
      div0_d     = (b_i == '0);
    end else if ((state_q == DivBusy) && !flush_i) begin
      cnt_d = cnt_q + CntW'(1);
      if (!trial[Width]) begin
        rem_d  = trial[Width-1:0];
        quot_d = {quot_q[Width-2:0], 1'b1};
      end else begin
        rem_d  = rem_shift[Width-1:0];
        quot_d = {quot_q[Width-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      div0_q     <= div0_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU plus iterative divider, registered
// toward EX/MEM.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reg_wr_addr_in/reg_wr_en_in     write-back target from ID/EX
//   reg_rd_data1_in/reg_rd_data2_in operands A / B
//   alusel_in, aluop_in             operation class / code
//   flush_in                        turn this cycle into a bubble
//   reg_wr_*_out                    registered write-back address/enable/data
//   hilo_wr_en_out, hi_out, lo_out  registered HI/LO write (remainder/quotient)
//   stall_req_out                   combinational stall while dividing
module ex_stage
  import mips_defines::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = RegAddrWidth,
  parameter int unsigned REG_DATA_WIDTH = RegDataWidth,
  parameter int unsigned ALUSEL_WIDTH   = AluselWidth,
  parameter int unsigned ALUOP_WIDTH    = AluopWidth
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
  input  logic                      reg_wr_en_in,
  input  logic [REG_DATA_WIDTH-1:0] reg_rd_data1_in,
  input  logic [REG_DATA_WIDTH-1:0] reg_rd_data2_in,
  input  logic [ALUSEL_WIDTH-1:0]   alusel_in,
  input  logic [ALUOP_WIDTH-1:0]    aluop_in,
  input  logic                      flush_in,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
  output logic                      reg_wr_en_out,
  output logic [REG_DATA_WIDTH-1:0] reg_wr_data_out,
  output logic                      hilo_wr_en_out,
  output logic [REG_DATA_WIDTH-1:0] hi_out,
  output logic [REG_DATA_WIDTH-1:0] lo_out,
  output logic                      stall_req_out
);

  localparam int unsigned ShW = $clog2(REG_DATA_WIDTH);
  localparam int unsigned Msb = REG_DATA_WIDTH - 1;

  logic [REG_DATA_WIDTH-1:0] a, b, sum, diff, alu_result, div_quot, div_rem;
  logic [ShW-1:0]            shamt;
  logic                      ovf, div_stall, div_done;

  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      en_q, en_d, hilo_en_q, hilo_en_d;
  logic [REG_DATA_WIDTH-1:0] data_q, data_d, hi_q, hi_d, lo_q, lo_d;

  assign a     = reg_rd_data1_in;
  assign b     = reg_rd_data2_in;
  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = a[ShW-1:0];

  ex_div #(
    .Width(REG_DATA_WIDTH)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (alusel_in == AluselDiv),
    .signed_i(aluop_in == AluopDiv),
    .flush_i (flush_in),
    .a_i     (a),
    .b_i     (b),
    .stall_o (div_stall),
    .done_o  (div_done),
    .quot_o  (div_quot),
    .rem_o   (div_rem)
  );

  // Gated so every output reads 0 while reset is held, even with a DIV presented.
  assign stall_req_out = div_stall & rst_n;

  always_comb begin
    alu_result = '0;
    ovf        = 1'b0;
    case (alusel_in)
      AluselLogic: begin
        case (aluop_in)
          AluopAnd: alu_result = a & b;
          AluopOr:  alu_result = a | b;
          AluopXor: alu_result = a ^ b;
          AluopNor: alu_result = ~(a | b);
          default:  alu_result = '0;
        endcase
      end
      AluselShift: begin
        case (aluop_in)
          AluopSll: alu_result = b << shamt;
          AluopSrl: alu_result = b >> shamt;
          AluopSra: alu_result = $signed(b) >>> shamt;
          default:  alu_result = '0;
        endcase
      end
      AluselArith: begin
        case (aluop_in)
          AluopAdd: begin
            alu_result = sum;
            ovf        = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
          end
          AluopAddu: alu_result = sum;
          AluopSub: begin
            alu_result = diff;
            ovf        = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
          end
          AluopSubu: alu_result = diff;
          AluopSlt:  alu_result = REG_DATA_WIDTH'($signed(a) < $signed(b));
          AluopSltu: alu_result = REG_DATA_WIDTH'(a < b);
          default:   alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    en_d      = en_q;
    data_d    = data_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hilo_en_d = 1'b0;
    if (flush_in) begin
      en_d = 1'b0;
    end else if (div_done) begin
      lo_d      = div_quot;
      hi_d      = div_rem;
      hilo_en_d = 1'b1;
      en_d      = 1'b0;
    end else if (div_stall) begin
      en_d = 1'b0;
    end else begin
      addr_d = reg_wr_addr_in;
      en_d   = reg_wr_en_in & ~ovf;
      data_d = alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      en_q      <= 1'b0;
      data_q    <= '0;
      hilo_en_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      addr_q    <= addr_d;
      en_q      <= en_d;
      data_q    <= data_d;
      hilo_en_q <= hilo_en_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign reg_wr_addr_out = addr_q;
  assign reg_wr_en_out   = en_q;
  assign reg_wr_data_out = data_q;
  assign hilo_wr_en_out  = hilo_en_q;
  assign hi_out          = hi_q;
  assign lo_out          = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import mips_defines::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  reg_wr_addr_in = '0;
  logic        reg_wr_en_in = 1'b0;
  logic [31:0] reg_rd_data1_in = '0;
  logic [31:0] reg_rd_data2_in = '0;
  logic [2:0]  alusel_in = '0;
  logic [7:0]  aluop_in = '0;
  logic        flush_in = 1'b0;
  logic [4:0]  reg_wr_addr_out;
  logic        reg_wr_en_out;
  logic [31:0] reg_wr_data_out;
  logic        hilo_wr_en_out;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        stall_req_out;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reg_wr_addr_in (reg_wr_addr_in),
    .reg_wr_en_in   (reg_wr_en_in),
    .reg_rd_data1_in(reg_rd_data1_in),
    .reg_rd_data2_in(reg_rd_data2_in),
    .alusel_in      (alusel_in),
    .aluop_in       (aluop_in),
    .flush_in       (flush_in),
    .reg_wr_addr_out(reg_wr_addr_out),
    .reg_wr_en_out  (reg_wr_en_out),
    .reg_wr_data_out(reg_wr_data_out),
    .hilo_wr_en_out (hilo_wr_en_out),
    .hi_out         (hi_out),
    .lo_out         (lo_out),
    .stall_req_out  (stall_req_out)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  addr;
    logic        en;
    logic [31:0] data;
    logic        exp_en;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic        en;
    logic [31:0] data;
    logic        hilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[18];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_data = '0;
  logic [4:0]  m_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty when output expected", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".addr"}, 32'(reg_wr_addr_out), 32'(e.addr));
      chk({tag, ".en"}, 32'(reg_wr_en_out), 32'(e.en));
      chk({tag, ".data"}, reg_wr_data_out, e.data);
      chk({tag, ".hilo_en"}, 32'(hilo_wr_en_out), 32'(e.hilo));
      chk({tag, ".hi"}, hi_out, e.hi);
      chk({tag, ".lo"}, lo_out, e.lo);
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    alusel_in       = v.sel;
    aluop_in        = v.op;
    reg_rd_data1_in = v.a;
    reg_rd_data2_in = v.b;
    reg_wr_addr_in  = v.addr;
    reg_wr_en_in    = v.en;
    flush_in        = 1'b0;
    sb.push_back('{addr: v.addr, en: v.exp_en, data: v.data, hilo: 1'b0, hi: m_hi, lo: m_lo});
    m_addr = v.addr;
    m_data = v.data;
    #1 chk({tag, ".stall"}, 32'(stall_req_out), 32'd0);
    @(posedge clk);
    #1 compare_out(tag);
  endtask

  // flush_cyc < 0: run to completion; otherwise assert flush on that stall cycle.
  task automatic div_seq(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi,
                         input int stall_exp, input int flush_cyc);
    int cnt = 0;
    bit ended = 1'b0;
    @(negedge clk);
    alusel_in       = AluselDiv;
    aluop_in        = op;
    reg_rd_data1_in = a;
    reg_rd_data2_in = b;
    reg_wr_addr_in  = 5'd3;
    reg_wr_en_in    = 1'b1;
    flush_in        = 1'b0;
    if (flush_cyc < 0) begin
      sb.push_back('{addr: m_addr, en: 1'b0, data: m_data, hilo: 1'b1, hi: hi, lo: lo});
      m_hi = hi;
      m_lo = lo;
    end
    for (int c = 0; c < 40 && !ended; c++) begin
      if (c > 0) @(negedge clk);
      if (c == flush_cyc) flush_in = 1'b1;
      #1;
      if (stall_req_out) begin
        cnt++;
        @(posedge clk);
        #1 chk({tag, ".bubble"}, {30'd0, reg_wr_en_out, hilo_wr_en_out}, 32'd0);
      end else begin
        ended = 1'b1;
      end
    end
    chk({tag, ".stall_cycles"}, 32'(cnt), 32'(stall_exp));
    @(posedge clk);
    #1;
    if (flush_cyc < 0) begin
      compare_out(tag);
    end else begin
      chk({tag, ".flush_hilo_en"}, 32'(hilo_wr_en_out), 32'd0);
      chk({tag, ".flush_en"}, 32'(reg_wr_en_out), 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{AluselArith, AluopAddu, 32'hFFFFFFFF, 32'h1, 5'd5, 1'b1, 32'h0, 1'b1};
    vecs[1]  = '{AluselArith, AluopAdd, 32'h7FFFFFFF, 32'h1, 5'd6, 1'b1, 32'h80000000, 1'b0};
    vecs[2]  = '{AluselArith, AluopSlt, 32'hFFFFFFFF, 32'h1, 5'd7, 1'b1, 32'h1, 1'b1};
    vecs[3]  = '{AluselArith, AluopSltu, 32'hFFFFFFFF, 32'h1, 5'd8, 1'b1, 32'h0, 1'b1};
    vecs[4]  = '{AluselLogic, AluopAnd, 32'hF0F000FF, 32'h0FF00F0F, 5'd9, 1'b1, 32'h00F0000F, 1'b1};
    vecs[5]  = '{AluselLogic, AluopOr, 32'h12000034, 32'h00005600, 5'd10, 1'b1, 32'h12005634, 1'b1};
    vecs[6]  = '{AluselLogic, AluopXor, 32'hFFFF0000, 32'h0F0F0F0F, 5'd11, 1'b1, 32'hF0F00F0F, 1'b1};
    vecs[7]  = '{AluselLogic, AluopNor, 32'h0, 32'h0, 5'd12, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[8]  = '{AluselShift, AluopSll, 32'h4, 32'h1, 5'd13, 1'b1, 32'h10, 1'b1};
    vecs[9]  = '{AluselShift, AluopSrl, 32'd31, 32'h80000000, 5'd14, 1'b1, 32'h1, 1'b1};
    vecs[10] = '{AluselShift, AluopSra, 32'h4, 32'h80000000, 5'd15, 1'b1, 32'hF8000000, 1'b1};
    vecs[11] = '{AluselShift, AluopSll, 32'h21, 32'h3, 5'd16, 1'b1, 32'h6, 1'b1};
    vecs[12] = '{AluselArith, AluopSub, 32'h80000000, 32'h1, 5'd17, 1'b1, 32'h7FFFFFFF, 1'b0};
    vecs[13] = '{AluselArith, AluopSubu, 32'h0, 32'h1, 5'd18, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[14] = '{AluselArith, AluopAdd, 32'h5, 32'hFFFFFFFD, 5'd19, 1'b1, 32'h2, 1'b1};
    vecs[15] = '{3'd7, AluopAnd, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, 1'b1, 32'h0, 1'b1};
    vecs[16] = '{AluselLogic, 8'hFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, 1'b1, 32'h0, 1'b1};
    vecs[17] = '{AluselNop, 8'h00, 32'h1234, 32'h5678, 5'd22, 1'b0, 32'h0, 1'b0};

    #1 rst_n = 1'b0;
    #1;
    chk("reset.outputs", {reg_wr_data_out[15:0], 11'd0, reg_wr_addr_out},  32'd0);
    chk("reset.flags", {29'd0, reg_wr_en_out, hilo_wr_en_out, stall_req_out}, 32'd0);
    chk("reset.hi", hi_out, 32'd0);
    chk("reset.lo", lo_out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back divisions: each is accepted the cycle after the previous DONE.
    div_seq("div_m7_2", AluopDiv, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, -1);
    div_seq("div_min_m1", AluopDiv, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 33, -1);
    div_seq("divu_100_7", AluopDivu, 32'd100, 32'd7, 32'd14, 32'd2, 33, -1);
    div_seq("divu_100_0", AluopDivu, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1, -1);
    div_seq("div_m9_0", AluopDiv, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF7, 1, -1);

    for (int i = 0; i < 4; i++) apply_vec(vecs[i], $sformatf("post_div%0d", i));

    div_seq("divu_flush", AluopDivu, 32'd100, 32'd7, 32'd0, 32'd0, 10, 10);
    for (int i = 0; i < 24; i++) apply_vec(vecs[17], $sformatf("flush_nop%0d", i));
    apply_vec('{AluselLogic, AluopOr, 32'h0000F000, 32'h0000000F, 5'd4, 1'b1,
                32'h0000F00F, 1'b1}, "ori_after_flush");

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    alusel_in       = AluselDiv;
    aluop_in        = AluopDivu;
    reg_rd_data1_in = 32'd1000;
    reg_rd_data2_in = 32'd3;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.addr", 32'(reg_wr_addr_out), 32'd0);
    chk("midreset.data", reg_wr_data_out, 32'd0);
    chk("midreset.flags", {29'd0, reg_wr_en_out, hilo_wr_en_out, stall_req_out}, 32'd0);
    chk("midreset.hi", hi_out, 32'd0);
    chk("midreset.lo", lo_out, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    alusel_in = AluselNop;
    rst_n     = 1'b1;
    for (int i = 4; i < 8; i++) apply_vec(vecs[i], $sformatf("post_reset%0d", i));
    div_seq("divu_after_reset", AluopDivu, 32'd1000, 32'd3, 32'd333, 32'd1, 33, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
